// File: rtl/tot_hit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tot_hit_buffer
// Brief    : Captures encoded TOT results from the phase encoder, range-checks
//            them, optionally drops flagged hits, and queues the rest in a
//            small FIFO read out via valid/ready. Saturating error/overflow
//            counters are kept for slow control.
// Revision : 1.0 - initial release
// ============================================================================
module tot_hit_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hitStrobe,
  input  logic [2:0]       coarsePhase,
  input  logic [5:0]       finePhase,
  input  logic             errorFlag,
  input  logic             dropErrors,
  input  logic             clearCounters,
  input  logic             doutReady,
  output logic             doutValid,
  output logic [9:0]       dout,
  output logic             fifoFull,
  output logic [CNT_W-1:0] errCount,
  output logic [CNT_W-1:0] ovfCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] c_depth_occ = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [5:0]       c_fine_max  = 6'd41;

  // Capture stage
  logic             s1_valid_q, s1_valid_d;
  logic             s1_flag_q, s1_flag_d;
  logic [2:0]       s1_coarse_q, s1_coarse_d;
  logic [5:0]       s1_fine_q, s1_fine_d;

  // FIFO storage and bookkeeping
  logic [9:0]       mem_q [DEPTH];
  logic [9:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [9:0]       dout_q, dout_d;

  // Counters
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  // Commit-stage decisions
  logic             w_pop;
  logic             w_space;
  logic             w_keep;
  logic             w_wr_en;
  logic             w_err_inc;
  logic             w_ovf_inc;
  logic [9:0]       w_wr_word;

  // Capture the encoder result on the strobe; out-of-range fine phase is flagged
  always_comb begin
    s1_valid_d  = hitStrobe;
    s1_flag_d   = s1_flag_q;
    s1_coarse_d = s1_coarse_q;
    s1_fine_d   = s1_fine_q;
    if (hitStrobe) begin
      s1_flag_d   = errorFlag | (finePhase > c_fine_max);
      s1_coarse_d = coarsePhase;
      s1_fine_d   = finePhase;
    end
  end

  // Decide whether the captured hit is written, dropped or lost to overflow
  always_comb begin
    w_pop     = valid_q & doutReady;
    w_space   = (occ_q < c_depth_occ) | w_pop;
    w_keep    = s1_valid_q & ~(s1_flag_q & dropErrors);
    w_wr_en   = w_keep & w_space;
    w_ovf_inc = w_keep & ~w_space;
    w_err_inc = s1_valid_q & s1_flag_q;
    w_wr_word = {s1_flag_q, s1_coarse_q, s1_fine_q};
  end

  // FIFO next state; dout is preloaded with the post-update head entry
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (w_wr_en) begin
      mem_d[wr_ptr_q] = w_wr_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_wr_en, w_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != '0);
    full_d  = (occ_d == c_depth_occ);
    // The new word becomes the head when it lands where the read pointer will be
    if (w_wr_en && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = w_wr_word;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // Saturating counters; a clear overrides any coincident increment
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clearCounters) begin
      err_d = '0;
      ovf_d = '0;
    end else begin
      if (w_err_inc && (err_q != c_cnt_max)) err_d = err_q + CNT_W'(1);
      if (w_ovf_inc && (ovf_q != c_cnt_max)) ovf_d = ovf_q + CNT_W'(1);
    end
  end

  // State registers with synchronous flush
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_flag_q   <= 1'b0;
      s1_coarse_q <= '0;
      s1_fine_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
      dout_q      <= '0;
      err_q       <= '0;
      ovf_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_flag_q   <= s1_flag_d;
      s1_coarse_q <= s1_coarse_d;
      s1_fine_q   <= s1_fine_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      valid_q     <= valid_d;
      full_q      <= full_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign doutValid = valid_q;
  assign dout      = dout_q;
  assign fifoFull  = full_q;
  assign errCount  = err_q;
  assign ovfCount  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tot_hit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tot_hit_buffer
// Brief    : Self-checking bench for tot_hit_buffer: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tot_hit_buffer;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             hitStrobe;
  logic [2:0]       coarsePhase;
  logic [5:0]       finePhase;
  logic             errorFlag;
  logic             dropErrors;
  logic             clearCounters;
  logic             doutReady;
  logic             doutValid;
  logic [9:0]       dout;
  logic             fifoFull;
  logic [CNT_W-1:0] errCount;
  logic [CNT_W-1:0] ovfCount;

  tot_hit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hitStrobe(hitStrobe), .coarsePhase(coarsePhase),
    .finePhase(finePhase), .errorFlag(errorFlag), .dropErrors(dropErrors),
    .clearCounters(clearCounters), .doutReady(doutReady), .doutValid(doutValid),
    .dout(dout), .fifoFull(fifoFull), .errCount(errCount), .ovfCount(ovfCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endfunction

  // Reference model: a queue holding FIFO contents plus one pending captured hit
  logic [9:0] mq[$];
  bit         m_pend;
  logic [9:0] m_pend_word;
  int         m_err;
  int         m_ovf;

  function automatic void model_step();
    bit pop, space, flag;
    if (reset) begin
      mq.delete();
      m_pend = 0; m_err = 0; m_ovf = 0;
      return;
    end
    pop   = (mq.size() != 0) && doutReady;
    space = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      flag = m_pend_word[9];
      if (flag) m_err = (m_err + 1 > CNT_MAX) ? CNT_MAX : m_err + 1;
      if (!(flag && dropErrors)) begin
        if (space) mq.push_back(m_pend_word);
        else m_ovf = (m_ovf + 1 > CNT_MAX) ? CNT_MAX : m_ovf + 1;
      end
    end
    if (clearCounters) begin
      m_err = 0; m_ovf = 0;
    end
    m_pend      = hitStrobe;
    m_pend_word = {errorFlag || (finePhase > 6'd41), coarsePhase, finePhase};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stb, input int c, input int f, input logic e,
                       input logic drop, input logic rdy, input logic clr);
    hitStrobe     = stb;
    coarsePhase   = 3'(c);
    finePhase     = 6'(f);
    errorFlag     = e;
    dropErrors    = drop;
    doutReady     = rdy;
    clearCounters = clr;
  endtask

  typedef struct {
    logic       stb;
    int         c, f;
    logic       e, drop, rdy, clr;
    logic       ev;
    logic [9:0] ed;
    logic       ef;
    int         eerr, eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic stb, input int c, input int f, input logic e,
                     input logic drop, input logic rdy, input logic clr,
                     input logic ev, input logic [9:0] ed, input logic ef,
                     input int eerr, input int eovf);
    vec_t v;
    v.stb = stb; v.c = c; v.f = f; v.e = e; v.drop = drop; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ef = ef; v.eerr = eerr; v.eovf = eovf;
    tbl.push_back(v);
  endtask

  function automatic logic [9:0] w(input int i);
    logic [2:0] c;
    logic [5:0] f;
    c = 3'(i);
    f = 6'(i + 10);
    return {1'b0, c, f};
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("reset doutValid", 32'(doutValid), 0);
    check("reset dout", 32'(dout), 0);
    check("reset fifoFull", 32'(fifoFull), 0);
    check("reset errCount", 32'(errCount), 0);
    check("reset ovfCount", 32'(ovfCount), 0);
    reset = 1'b0;

    // Single clean hit, 2-cycle latency
    add(1, 3, 17, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0, 1, 10'h0D1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
    // Out-of-range fine phase: queued flagged, then dropped
    add(1, 5, 45, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0, 1, 10'h36D, 0, 1, 0);
    add(0, 0, 0,  0, 0, 1, 0, 0, 10'h000, 0, 1, 0);
    add(1, 5, 45, 0, 1, 0, 0, 0, 10'h000, 0, 1, 0);
    add(0, 0, 0,  0, 1, 0, 0, 0, 10'h000, 0, 2, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 10'h000, 0, 2, 0);
    // Six back-to-back strobes into a stalled FIFO, then drain
    for (int i = 0; i < 6; i++)
      add(1, i, i + 10, 0, 0, 0, 0, i >= 1, w(0), i >= 4, 2, (i == 5) ? 1 : 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, w(0), 1, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(1), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(2), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(3), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 10'h000, 0, 2, 2);
    // Fill to full, then commit a hit on the same cycle as a pop
    for (int i = 0; i < 5; i++)
      add(1, i, i + 10, 0, 0, 0, 0, i >= 1, w(0), i >= 4, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(1), 1, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(2), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(3), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, w(4), 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 10'h000, 0, 2, 2);
    // Fine-phase boundary 41 (legal) vs 42 (flagged), then empty reads
    add(1, 7, 41, 0, 0, 0, 0, 0, 10'h000, 0, 2, 2);
    add(1, 0, 42, 0, 0, 0, 0, 1, 10'h1E9, 0, 2, 2);
    add(0, 0, 0,  0, 0, 0, 0, 1, 10'h1E9, 0, 3, 2);
    add(0, 0, 0,  0, 0, 1, 0, 1, 10'h22A, 0, 3, 2);
    add(0, 0, 0,  0, 0, 1, 0, 0, 10'h000, 0, 3, 2);
    add(0, 0, 0,  0, 0, 1, 0, 0, 10'h000, 0, 3, 2);

    foreach (tbl[k]) begin
      drive(tbl[k].stb, tbl[k].c, tbl[k].f, tbl[k].e, tbl[k].drop, tbl[k].rdy, tbl[k].clr);
      tick();
      check($sformatf("vec%0d doutValid", k), 32'(doutValid), 32'(tbl[k].ev));
      check($sformatf("vec%0d fifoFull", k), 32'(fifoFull), 32'(tbl[k].ef));
      check($sformatf("vec%0d errCount", k), 32'(errCount), tbl[k].eerr);
      check($sformatf("vec%0d ovfCount", k), 32'(ovfCount), tbl[k].eovf);
      if (tbl[k].ev) check($sformatf("vec%0d dout", k), 32'(dout), 32'(tbl[k].ed));
    end

    // Error counter saturation with flagged hits being dropped
    for (int i = 0; i < 300; i++) begin
      drive(1, i, (i % 2) ? 0 : 50, i % 2, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    check("sat errCount", 32'(errCount), CNT_MAX);
    check("sat ovfCount", 32'(ovfCount), 2);
    check("sat doutValid", 32'(doutValid), 0);

    // Clear coinciding with a flagged commit: the clear wins
    drive(1, 2, 0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 1);
    tick();
    check("clear errCount", 32'(errCount), 0);
    check("clear ovfCount", 32'(ovfCount), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post-clear errCount", 32'(errCount), 0);

    // Reset with three queued words and one in the capture stage
    for (int i = 0; i < 4; i++) begin
      drive(1, i, i + 10, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pre-reset dout", 32'(dout), 32'(w(0)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush doutValid", 32'(doutValid), 0);
    check("flush fifoFull", 32'(fifoFull), 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, i % 2, 0);
      tick();
      check($sformatf("no stale word %0d", i), 32'(doutValid), 0);
    end
    drive(1, 2, 33, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post-reset doutValid", 32'(doutValid), 1);
    check("post-reset dout", 32'(dout), 32'h0A1);
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    check("post-reset drained", 32'(doutValid), 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (i % 60 == 0) dropErrors = $urandom_range(0, 1);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 63),
            $urandom_range(0, 9) == 0, dropErrors, $urandom_range(0, 9) < ((i / 100) % 2 ? 3 : 7),
            $urandom_range(0, 49) == 0);
      tick();
      check("rnd doutValid", 32'(doutValid), 32'(mq.size() != 0));
      check("rnd fifoFull", 32'(fifoFull), 32'(mq.size() == DEPTH));
      check("rnd errCount", 32'(errCount), m_err);
      check("rnd ovfCount", 32'(ovfCount), m_ovf);
      if (mq.size() != 0) check("rnd dout", 32'(dout), 32'(mq[0]));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tot_hit_buffer.md
Name: tot_hit_buffer

Overview:
- Downstream consumer of the TOT phase encoder in the ETROC2 TDC.
- Captures each encoded TOT result (coarse phase, fine phase and error flag) on a conversion strobe.
- Range-checks the result, optionally discards flagged hits, and queues the rest in a small FIFO for readout through a valid/ready handshake.
- Keeps saturating error and overflow counters for slow control.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of the error and overflow counters

Ports:
clk  input  1  TDC clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
hitStrobe  input  1  one-cycle pulse; encoder outputs are valid this cycle
coarsePhase  input  3  corrected coarse phase from the encoder
finePhase  input  6  corrected fine phase from the encoder; legal range 0..41
errorFlag  input  1  encoder bubble/tolerance error
dropErrors  input  1  config, quasi-static: 1 = discard flagged hits instead of queuing them
clearCounters  input  1  synchronous pulse; zeroes both counters
doutReady  input  1  readout accepts the word
doutValid  output  1  FIFO head is valid
dout  output  10  {flag, coarsePhase[2:0], finePhase[5:0]}
fifoFull  output  1  occupancy == DEPTH
errCount  output  CNT_W  saturating count of flagged hits
ovfCount  output  CNT_W  saturating count of hits lost because the FIFO was full

Behaviour:
- Reset values (synchronous reset): doutValid=0, dout=0, fifoFull=0, errCount=0, ovfCount=0. Capture-stage valid is cleared, occupancy=0, and read/write pointers=0.
- Reset asserted mid-operation flushes all queued and in-flight hits. No output word follows reset until a new hitStrobe arrives.
- Stage 1 (capture), on the cycle hitStrobe=1:
  - Register coarsePhase and finePhase.
  - Register flag = errorFlag OR (finePhase > 41).
  - Set s1Valid=1 for exactly one cycle.
  - Back-to-back strobes are legal, one hit per cycle.
- Stage 2 (commit), when s1Valid=1:
  - If flag=1: errCount increments, saturating at 2^CNT_W-1.
  - If flag=1 and dropErrors=1: the hit is not written; ovfCount is unaffected.
  - Otherwise, if the FIFO has space: write {flag, coarse, fine} at wrPtr and advance wrPtr modulo DEPTH.
  - Otherwise (FIFO full): do not write; ovfCount increments, saturating.
  - A flagged hit that overflows increments both counters.
- FIFO space rule: space = (occupancy < DEPTH) OR (doutValid AND doutReady in the same cycle). A simultaneous pop on a full FIFO accepts the write.
- Read side:
  - doutValid = (occupancy != 0).
  - dout is driven from a registered copy of the head entry and is stable while doutValid=1 and doutReady=0.
  - A pop occurs when doutValid AND doutReady; it advances rdPtr modulo DEPTH.
  - Occupancy: +1 on write only, -1 on pop only, unchanged on both.
- Latency: hitStrobe at cycle N gives doutValid=1 with that word at cycle N+2 if the FIFO was empty. Fall-through is 2 cycles; there is no same-cycle bypass.
- Empty-read: doutReady with doutValid=0 has no effect; pointers do not move.
- Ordering: strict FIFO order; no reordering or duplication.
- Counters:
  - clearCounters=1 zeroes both counters that cycle. Increments coinciding with clearCounters are lost; the clear wins.
  - Counters never wrap.
- fifoFull is registered and reflects post-update occupancy.
- No internal combinational path from doutReady to doutValid.

Test Plan:
- Reset, then a single strobe with coarse=3, fine=17, errorFlag=0 -> dout=0x0D1 ({0,3'd3,6'd17}), doutValid at strobe+2 cycles, errCount=0.
- Strobe with fine=45, errorFlag=0, dropErrors=0 -> word queued with flag=1 (dout=0x200|{coarse,6'd45}), errCount=1. Repeat with dropErrors=1 -> no word queued, errCount=2.
- doutReady=0, 6 back-to-back clean strobes with DEPTH=4 -> first 4 queued, fifoFull=1, ovfCount=2. Then drain -> exactly those 4 words in order.
- FIFO full with doutReady=1 on the same cycle a new hit commits -> hit accepted, occupancy stays 4, ovfCount unchanged.
- CNT_W=8, 300 flagged strobes -> errCount saturates at 255. Pulse clearCounters coinciding with a flagged hit -> errCount=0.
- Reset asserted with 3 words queued and 1 in stage 1 -> the next cycle has doutValid=0 and fifoFull=0, and no stale word ever appears afterwards.
